// File: rtl/booth_datapath.sv
// Register/arithmetic datapath of the Booth multiplier: A, Q, Q-1 and M registers
// driven by per-cycle control codes, with product capture on the rising edge of done_sig.
module booth_datapath #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 M_sig,
    input  logic                 adder_sig,
    input  logic [1:0]           A_sig,
    input  logic [1:0]           Q_sig,
    input  logic                 done_sig,
    output logic [1:0]           Q_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_RESET = 2'b01,
        OP_SHIFT = 2'b10,
        OP_HOLD  = 2'b11
    } reg_op_e;

    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1;
    logic [WIDTH-1:0] m_q;
    logic             done_r;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_sum;
    logic             done_rise;
    reg_op_e          a_op;
    reg_op_e          q_op;

    // A is one bit wider than the operands so that subtracting M = -2^(WIDTH-1) cannot overflow.
    assign m_ext     = {m_q[WIDTH-1], m_q};
    assign a_sum     = adder_sig ? (a_q - m_ext) : (a_q + m_ext);
    assign done_rise = done_sig && !done_r;
    assign a_op      = reg_op_e'(A_sig);
    assign q_op      = reg_op_e'(Q_sig);
    assign Q_in      = {q_q[0], q_m1};

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q           <= '0;
            q_q           <= '0;
            q_m1          <= 1'b0;
            m_q           <= '0;
            done_r        <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register below read pre-edge values,
            // which is what lets A Shift and Q Shift form one combined {A,Q,Q-1} shift.
            unique case (a_op)
                OP_LOAD:  a_q <= a_sum;
                OP_RESET: a_q <= '0;
                OP_SHIFT: a_q <= {a_q[WIDTH], a_q[WIDTH:1]};
                OP_HOLD:  a_q <= a_q;
            endcase

            unique case (q_op)
                OP_LOAD: begin
                    q_q  <= multiplier;
                    q_m1 <= 1'b0;
                end
                OP_RESET: begin
                    q_q  <= '0;
                    q_m1 <= 1'b0;
                end
                OP_SHIFT: begin
                    q_q  <= {a_q[0], q_q[WIDTH-1:1]};
                    q_m1 <= q_q[0];
                end
                OP_HOLD: begin
                    q_q  <= q_q;
                    q_m1 <= q_m1;
                end
            endcase

            if (M_sig) begin
                m_q <= multiplicand;
            end

            done_r        <= done_sig;
            product_valid <= done_rise;
            if (done_rise) begin
                product <= {a_q[WIDTH-1:0], q_q};
            end
        end
    end

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
- Register/arithmetic datapath of the Booth multiplier. It sits directly downstream of the Booth control FSM.
- Consumes the FSM's per-cycle control codes (Q_sig, A_sig, M_sig, adder_sig, done_sig).
- Holds the A, Q, Q-1 and M registers and performs add/subtract and arithmetic shift right.
- Returns the 2-bit Booth decision pair Q_in to the FSM, and captures the final signed product when the FSM signals done.

Parameters:
WIDTH, 4, operand width in bits (signed two's complement); product is 2*WIDTH bits

Ports:
clock  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
multiplicand  input  WIDTH  signed operand loaded into M
multiplier  input  WIDTH  signed operand loaded into Q
M_sig  input  1  1=LD (load M), 0=HD (hold M)
adder_sig  input  1  0=Add (A+M), 1=Sub (A-M)
A_sig  input  2  A register op: 00=Load, 01=Reset, 10=Shift, 11=Hold
Q_sig  input  2  Q/Q-1 register op: 00=Load, 01=Reset, 10=Shift, 11=Hold
done_sig  input  1  from control FSM; rising edge triggers product capture
Q_in  output  2  {Q[0], Q-1} to control FSM, combinational from registers
product  output  2*WIDTH  captured signed product, held until next capture
product_valid  output  1  one-cycle pulse when product updates

Behaviour:
- Reset:
  - Applies on the clock edge only and has priority over every control code.
  - Clears A, Q, Q-1, M, product, product_valid and the done-edge history register to 0.
  - Hence Q_in=00.
- A register:
  - A is WIDTH+1 bits internally; M is sign-extended to WIDTH+1 bits. This makes M = -2^(WIDTH-1) legal.
  - A Load: A <= A + Mext (adder_sig=0) or A - Mext (adder_sig=1), modulo 2^(WIDTH+1).
  - A Reset: A <= 0.
  - A Shift: A <= {A[WIDTH], A[WIDTH:1]} (arithmetic right shift).
  - A Hold: unchanged.
- Q register:
  - Q Load: Q <= multiplier, Q-1 <= 0.
  - Q Reset: Q <= 0, Q-1 <= 0.
  - Q Shift: Q <= {A[0], Q[WIDTH-1:1]}, Q-1 <= Q[0].
  - Q Hold: unchanged.
- M register: M_sig=1 loads multiplicand; M_sig=0 holds.
- Simultaneous events: all registers update from pre-edge values.
  - A Load in the same cycle as M_sig=1 uses the old M.
  - Q Shift always takes the pre-edge A[0], whatever A_sig is that cycle. A Shift and Q Shift together form the {A,Q,Q-1} combined shift.
- Q_in:
  - Q_in = {Q[0], Q-1}, purely combinational.
  - It changes in the same cycle the registers change; there is no extra latency.
- Product capture:
  - done_r is a registered copy of done_sig.
  - On an edge where done_sig=1 and done_r=0: product <= {A[WIDTH-1:0], Q} and product_valid <= 1 for exactly one cycle.
  - done_sig held high for N cycles yields one pulse.
  - A done rising edge coincident with register ops captures the pre-edge A/Q values.
- product_valid is 0 in all other cycles. product holds its value across subsequent Loads/Resets until the next capture.
- Reset mid-operation: everything clears on that edge. An in-flight done edge is discarded; no pulse follows.
- Latency: control code applied in cycle n → register result visible after edge n. Product visible one edge after done rises.
- No illegal encodings; every code is defined above.

Test Plan:
1. reset=1 for 2 cycles with arbitrary control codes → A=0, Q=0, Q-1=0, M=0, Q_in=00, product=0, product_valid=0.
2. WIDTH=4, multiplicand=3, multiplier=5; Q_sig=Load, A_sig=Reset, M_sig=1 for one cycle → Q=0101, Q-1=0, M=0011, A=0, Q_in=10.
3. From step 2: A_sig=Load, adder_sig=1 → A=11101 (-3). Then A_sig=Shift, Q_sig=Shift → A=11110, Q=1010, Q-1=1, Q_in=01.
4. Full Booth sequence for 3×5 driven by the bench, then done_sig held high 3 cycles → product=8'h0F, product_valid high exactly one cycle; product stays 0F after a following Q Load.
5. multiplicand=-8, multiplier=-8 full sequence → product=8'h40. Also 7×(-8) → product=8'hC8.
6. Assert reset in the cycle done_sig rises mid-sequence → no product_valid pulse, all registers 0 next cycle; a subsequent clean 2×3 run gives product=8'h06.
